snes_mem_responder: RTL
=======================

Name: snes_mem_responder

Overview:
- Responder behind the SNES address decoder: takes the decoded ROM/SRAM address and hit/class flags plus SNES read/write strobes, and runs the 16-bit external memory cycle.
- Returns read bytes to the SNES data path and commits writes.
- Arbitrates one MCU request port in the gaps between SNES accesses, SNES first.
- Sits between the address decoder and the external PSRAM pins in the Cx4 top level.

Parameters:
RD_CYCLES, 5, CLK cycles OE_n held low per read (1..15)
WR_CYCLES, 4, CLK cycles WE_n held low per write (1..15)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
ROM_ADDR  in  24  decoded byte address from decoder
ROM_HIT  in  1  address maps to external memory
IS_WRITABLE  in  1  address may be written
IS_SAVERAM  in  1  address is save RAM
SNES_RD_START  in  1  one-cycle pulse: SNES read begins
SNES_WR_END  in  1  one-cycle pulse: SNES write data stable
SNES_DATA_IN  in  8  SNES write data
SNES_DATA_OUT  out  8  read byte to SNES
SNES_DATA_VALID  out  1  one-cycle pulse, SNES_DATA_OUT updated
MCU_RRQ  in  1  MCU read request pulse
MCU_WRQ  in  1  MCU write request pulse
MCU_ADDR  in  24  MCU byte address
MCU_DOUT  in  8  MCU write data
MCU_DIN  out  8  MCU read data
MCU_RDY  out  1  one-cycle pulse, MCU access complete
MEM_ADDR  out  23  word address (byte address [23:1])
MEM_DIN  in  16  memory read bus
MEM_DOUT  out  16  memory write bus, byte replicated on both lanes
MEM_OE_N  out  1  output enable, active low
MEM_WE_N  out  1  write enable, active low
MEM_BHE_N  out  1  high byte enable, active low
MEM_BLE_N  out  1  low byte enable, active low
BUSY  out  1  memory cycle in progress

Behaviour:
- Reset values: all outputs 0 except MEM_OE_N, MEM_WE_N, MEM_BHE_N and MEM_BLE_N, which are 1. State IDLE, pending flags cleared.
- Reset mid-cycle: strobes deassert in the cycle after RST is sampled; the in-flight access is abandoned; no VALID/RDY is issued.
- Request latching: requests are latched into pending flags together with address/data on their strobe, in any state.
  - SNES_RD_START is latched only if ROM_HIT=1. Otherwise it is ignored and no VALID is generated.
  - SNES_WR_END is latched only if ROM_HIT & IS_WRITABLE. Otherwise it is dropped.
  - A new SNES strobe while an SNES request is still pending overwrites the pending one (most recent wins).
  - MCU requests are latched likewise; a second MCU strobe while one is pending is ignored.
- States: IDLE, SRD, SWR, MRD, MWR, REC.
- IDLE selects the next request by priority: pending SNES read > pending SNES write > pending MCU read > pending MCU write. Selection takes 1 cycle.
  - The selected address drives MEM_ADDR.
  - Lane: address bit0=0 enables the low lane (BLE_N=0); bit0=1 enables the high lane (BHE_N=0). The other lane stays 1.
- SRD/MRD:
  - OE_N is low for exactly RD_CYCLES cycles.
  - On the last cycle the selected lane of MEM_DIN is captured to SNES_DATA_OUT or MCU_DIN.
  - VALID or RDY pulses the following cycle.
  - Next state REC.
- SWR/MWR:
  - MEM_DOUT is set to {data,data} one cycle before WE_N falls.
  - WE_N is low for WR_CYCLES cycles.
  - RDY pulses (MCU only) on WE_N rising.
  - Next state REC.
- REC: 1 cycle with all strobes high, then IDLE.
- BUSY = state != IDLE.
- The pending flag is cleared on entry to the service state, so a same-cycle re-strobe is captured as a new request.
- Read latency: SNES_RD_START to SNES_DATA_VALID is RD_CYCLES+2 cycles from IDLE, i.e. 7 at the default RD_CYCLES=5.
- Worst-case SNES latency: a full MCU write in progress plus REC.
- Address widths: bit 23 of ROM_ADDR/MCU_ADDR maps to MEM_ADDR[22]; no wrap handling is needed.
- Exclusivity: WE_N and OE_N are never low in the same cycle.

Optional Feature:
- Macro: SAVERAM_DIRTY_EN.
- With the macro defined:
  - Adds output SAVERAM_DIRTY (1 bit) and input DIRTY_CLR (1 bit).
  - SAVERAM_DIRTY sets on the first cycle of any SWR whose latched IS_SAVERAM=1.
  - DIRTY_CLR clears it. If set and clear coincide, set wins.
  - Reset value 0.
- Without the macro: the ports are absent and the logic is removed.

Test Plan:
- Read, even address: ROM_ADDR=0x008000, ROM_HIT=1, pulse SNES_RD_START; MEM_DIN=0x55AA -> MEM_ADDR=0x004000, BLE_N=0, OE_N low 5 cycles, SNES_DATA_OUT=0xAA, VALID 7 cycles after the strobe.
- Write to non-writable address: ROM_ADDR=0x008001, IS_WRITABLE=0, pulse SNES_WR_END -> no WE_N activity, BUSY stays 0.
- Write to save RAM: ROM_ADDR=0xE00003, IS_WRITABLE=1, IS_SAVERAM=1, data 0x3C -> MEM_ADDR=0x700001, BHE_N=0, MEM_DOUT=0x3C3C, WE_N low 4 cycles; with SAVERAM_DIRTY_EN, DIRTY=1.
- Simultaneous requests: MCU_RRQ (0x000010) and SNES_RD_START in the same cycle -> SNES read serviced first, then REC, then MCU read; MCU_RDY after SNES_DATA_VALID.
- SNES read mid-MCU write: SNES read arrives during MWR -> MCU write completes, SNES read starts right after REC, VALID correct.
- Reset mid-cycle: RST asserted during SRD with OE_N low -> OE_N=1 next cycle, no VALID, state IDLE, a later read behaves normally.

Source files
------------

// File: rtl/snes_mem_responder_if.sv
// Bus bundle between the SNES-side decoder, the MCU request port and the
// external PSRAM pins. The slave modport is the responder's view; master is
// the view of whatever drives requests and models the memory.
// Optional macro SAVERAM_DIRTY_EN adds the save-RAM dirty flag signals.
interface snes_mem_responder_if;
  logic [23:0] ROM_ADDR;
  logic        ROM_HIT;
  logic        IS_WRITABLE;
  logic        IS_SAVERAM;
  logic        SNES_RD_START;
  logic        SNES_WR_END;
  logic [7:0]  SNES_DATA_IN;
  logic [7:0]  SNES_DATA_OUT;
  logic        SNES_DATA_VALID;
  logic        MCU_RRQ;
  logic        MCU_WRQ;
  logic [23:0] MCU_ADDR;
  logic [7:0]  MCU_DOUT;
  logic [7:0]  MCU_DIN;
  logic        MCU_RDY;
  logic [22:0] MEM_ADDR;
  logic [15:0] MEM_DIN;
  logic [15:0] MEM_DOUT;
  logic        MEM_OE_N;
  logic        MEM_WE_N;
  logic        MEM_BHE_N;
  logic        MEM_BLE_N;
  logic        BUSY;
`ifdef SAVERAM_DIRTY_EN
  logic        SAVERAM_DIRTY;
  logic        DIRTY_CLR;
`endif

  modport slave (
`ifdef SAVERAM_DIRTY_EN
    input  DIRTY_CLR,
    output SAVERAM_DIRTY,
`endif
    input  ROM_ADDR, ROM_HIT, IS_WRITABLE, IS_SAVERAM,
    input  SNES_RD_START, SNES_WR_END, SNES_DATA_IN,
    output SNES_DATA_OUT, SNES_DATA_VALID,
    input  MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT,
    output MCU_DIN, MCU_RDY,
    output MEM_ADDR, MEM_DOUT, MEM_OE_N, MEM_WE_N, MEM_BHE_N, MEM_BLE_N,
    input  MEM_DIN,
    output BUSY
  );

  modport master (
`ifdef SAVERAM_DIRTY_EN
    output DIRTY_CLR,
    input  SAVERAM_DIRTY,
`endif
    output ROM_ADDR, ROM_HIT, IS_WRITABLE, IS_SAVERAM,
    output SNES_RD_START, SNES_WR_END, SNES_DATA_IN,
    input  SNES_DATA_OUT, SNES_DATA_VALID,
    output MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT,
    input  MCU_DIN, MCU_RDY,
    input  MEM_ADDR, MEM_DOUT, MEM_OE_N, MEM_WE_N, MEM_BHE_N, MEM_BLE_N,
    output MEM_DIN,
    input  BUSY
  );
endinterface

// File: rtl/snes_mem_responder.sv
// External 16-bit memory responder: serves SNES reads/writes from the address
// decoder and fits one MCU request port into the gaps, SNES first.
// Every memory pin is registered so strobes are glitch-free.
// Optional macro SAVERAM_DIRTY_EN adds a sticky save-RAM dirty flag.
module snes_mem_responder #(
  parameter int RD_CYCLES = 5,
  parameter int WR_CYCLES = 4
) (
  input logic CLK,
  input logic RST,
  snes_mem_responder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SRD, SWR, MRD, MWR, REC} state_t;

  localparam logic [3:0] RD_LAST = 4'(RD_CYCLES - 1);
  localparam logic [3:0] WR_LAST = 4'(WR_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [22:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_dout_q, mem_dout_d;
  logic        oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic        bhe_n_q, bhe_n_d, ble_n_q, ble_n_d;
  logic [7:0]  snes_data_q, snes_data_d, mcu_din_q, mcu_din_d;
  logic        snes_valid_q, snes_valid_d, mcu_rdy_q, mcu_rdy_d;

  // Single pending slot per requester: SNES slot is overwritten, MCU slot is not
  logic        s_pend_q, s_wr_q, m_pend_q, m_wr_q;
  logic [23:0] s_addr_q, m_addr_q;
  logic [7:0]  s_data_q, m_data_q;
  logic        s_take, m_take;
  logic [7:0]  rd_byte;

  // The enabled lane is the only one carrying valid read data
  assign rd_byte = bhe_n_q ? bus.MEM_DIN[7:0] : bus.MEM_DIN[15:8];

  // State and registered pin/output update
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_dout_q   <= '0;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      bhe_n_q      <= 1'b1;
      ble_n_q      <= 1'b1;
      snes_data_q  <= '0;
      snes_valid_q <= 1'b0;
      mcu_din_q    <= '0;
      mcu_rdy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_dout_q   <= mem_dout_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      bhe_n_q      <= bhe_n_d;
      ble_n_q      <= ble_n_d;
      snes_data_q  <= snes_data_d;
      snes_valid_q <= snes_valid_d;
      mcu_din_q    <= mcu_din_d;
      mcu_rdy_q    <= mcu_rdy_d;
    end
  end

  // Request selection, memory cycle sequencing and completion pulses
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_dout_d   = mem_dout_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    bhe_n_d      = bhe_n_q;
    ble_n_d      = ble_n_q;
    snes_data_d  = snes_data_q;
    snes_valid_d = 1'b0;
    mcu_din_d    = mcu_din_q;
    mcu_rdy_d    = 1'b0;
    s_take       = 1'b0;
    m_take       = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_pend_q) begin
          s_take     = 1'b1;
          mem_addr_d = s_addr_q[23:1];
          ble_n_d    = s_addr_q[0];
          bhe_n_d    = ~s_addr_q[0];
          if (s_wr_q) begin
            state_d    = SWR;
            mem_dout_d = {s_data_q, s_data_q};
          end else begin
            state_d = SRD;
            oe_n_d  = 1'b0;
            cnt_d   = RD_LAST;
          end
        end else if (m_pend_q) begin
          m_take     = 1'b1;
          mem_addr_d = m_addr_q[23:1];
          ble_n_d    = m_addr_q[0];
          bhe_n_d    = ~m_addr_q[0];
          if (m_wr_q) begin
            state_d    = MWR;
            mem_dout_d = {m_data_q, m_data_q};
          end else begin
            state_d = MRD;
            oe_n_d  = 1'b0;
            cnt_d   = RD_LAST;
          end
        end
      end
      SRD, MRD: begin
        if (cnt_q == 4'd0) begin
          oe_n_d  = 1'b1;
          bhe_n_d = 1'b1;
          ble_n_d = 1'b1;
          state_d = REC;
          if (state_q == SRD) begin
            snes_data_d  = rd_byte;
            snes_valid_d = 1'b1;
          end else begin
            mcu_din_d = rd_byte;
            mcu_rdy_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SWR, MWR: begin
        if (we_n_q) begin
          // Data has been on the bus for one cycle; now open the write pulse
          we_n_d = 1'b0;
          cnt_d  = WR_LAST;
        end else if (cnt_q == 4'd0) begin
          we_n_d    = 1'b1;
          bhe_n_d   = 1'b1;
          ble_n_d   = 1'b1;
          state_d   = REC;
          mcu_rdy_d = (state_q == MWR);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REC: state_d = IDLE;
      default: begin
        state_d = IDLE;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        bhe_n_d = 1'b1;
        ble_n_d = 1'b1;
      end
    endcase
  end

  // SNES request capture; a strobe in the take cycle starts a fresh request
  always_ff @(posedge CLK) begin
    if (RST) begin
      s_pend_q <= 1'b0;
      s_wr_q   <= 1'b0;
      s_addr_q <= '0;
      s_data_q <= '0;
    end else if (bus.SNES_RD_START && bus.ROM_HIT) begin
      s_pend_q <= 1'b1;
      s_wr_q   <= 1'b0;
      s_addr_q <= bus.ROM_ADDR;
    end else if (bus.SNES_WR_END && bus.ROM_HIT && bus.IS_WRITABLE) begin
      s_pend_q <= 1'b1;
      s_wr_q   <= 1'b1;
      s_addr_q <= bus.ROM_ADDR;
      s_data_q <= bus.SNES_DATA_IN;
    end else if (s_take) begin
      s_pend_q <= 1'b0;
    end
  end

  // MCU request capture; a second strobe while still pending is dropped
  always_ff @(posedge CLK) begin
    if (RST) begin
      m_pend_q <= 1'b0;
      m_wr_q   <= 1'b0;
      m_addr_q <= '0;
      m_data_q <= '0;
    end else if ((bus.MCU_RRQ || bus.MCU_WRQ) && (!m_pend_q || m_take)) begin
      m_pend_q <= 1'b1;
      m_wr_q   <= !bus.MCU_RRQ;
      m_addr_q <= bus.MCU_ADDR;
      m_data_q <= bus.MCU_DOUT;
    end else if (m_take) begin
      m_pend_q <= 1'b0;
    end
  end

`ifdef SAVERAM_DIRTY_EN
  logic s_sav_q, dirty_q;

  // Save-RAM class travels with the SNES request
  always_ff @(posedge CLK) begin
    if (RST) begin
      s_sav_q <= 1'b0;
    end else if ((bus.SNES_RD_START && bus.ROM_HIT) ||
                 (bus.SNES_WR_END && bus.ROM_HIT && bus.IS_WRITABLE)) begin
      s_sav_q <= bus.IS_SAVERAM;
    end
  end

  // Sticky dirty flag, raised as a save-RAM write cycle begins; set beats clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      dirty_q <= 1'b0;
    end else if (state_q == IDLE && s_pend_q && s_wr_q && s_sav_q) begin
      dirty_q <= 1'b1;
    end else if (bus.DIRTY_CLR) begin
      dirty_q <= 1'b0;
    end
  end

  assign bus.SAVERAM_DIRTY = dirty_q;
`endif

  assign bus.SNES_DATA_OUT   = snes_data_q;
  assign bus.SNES_DATA_VALID = snes_valid_q;
  assign bus.MCU_DIN         = mcu_din_q;
  assign bus.MCU_RDY         = mcu_rdy_q;
  assign bus.MEM_ADDR        = mem_addr_q;
  assign bus.MEM_DOUT        = mem_dout_q;
  assign bus.MEM_OE_N        = oe_n_q;
  assign bus.MEM_WE_N        = we_n_q;
  assign bus.MEM_BHE_N       = bhe_n_q;
  assign bus.MEM_BLE_N       = ble_n_q;
  assign bus.BUSY            = (state_q != IDLE);
endmodule
